// File: rtl/cache_controller.sv
// Control FSM for the direct-mapped cache: zero-wait read hits, 4-word line fills on read
// misses, and write-through stores with no write-allocate.
module cache_controller #(
    parameter int unsigned cache_width  = 128,
    parameter int unsigned memory_width = 32,
    parameter int unsigned addr_width   = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cpu_read,
    input  logic                    cpu_write,
    input  logic [addr_width-1:0]   cpu_addr,
    input  logic [memory_width-1:0] cpu_wdata,
    output logic                    stall,
    input  logic                    hit,
    output logic                    refill,
    output logic                    update,
    output logic [1:0]              offset,
    output logic [4:0]              index,
    output logic [addr_width-8:0]   tag,
    output logic [cache_width-1:0]  line_data,
    output logic [memory_width-1:0] write_data,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [addr_width-1:0]   mem_addr,
    output logic [memory_width-1:0] mem_wdata,
    input  logic [memory_width-1:0] mem_rdata,
    input  logic                    mem_ready
);

    typedef enum logic [1:0] {StIdle, StFill, StRefill, StWriteMem} state_e;

    state_e                   state_q;
    logic [1:0]               wcnt_q;
    logic [cache_width-1:0]   line_q;

    assign offset     = cpu_addr[1:0];
    assign index      = cpu_addr[6:2];
    assign tag        = cpu_addr[addr_width-1:7];
    assign write_data = cpu_wdata;
    assign mem_wdata  = cpu_wdata;
    assign line_data  = line_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            wcnt_q  <= '0;
            line_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    // Writes win when both requests are raised together.
                    if (cpu_write) begin
                        state_q <= StWriteMem;
                    end else if (cpu_read && !hit) begin
                        wcnt_q  <= '0;
                        state_q <= StFill;
                    end
                end
                StFill: begin
                    if (mem_ready) begin
                        line_q[memory_width*wcnt_q +: memory_width] <= mem_rdata;
                        wcnt_q <= wcnt_q + 2'd1;
                        if (wcnt_q == 2'd3) state_q <= StRefill;
                    end
                end
                StRefill: state_q <= StIdle;
                StWriteMem: begin
                    if (mem_ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        stall     = 1'b0;
        refill    = 1'b0;
        update    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = cpu_addr;
        case (state_q)
            StIdle: stall = cpu_write | (cpu_read & ~hit);
            StFill: begin
                stall    = 1'b1;
                mem_read = 1'b1;
                mem_addr = {cpu_addr[addr_width-1:2], wcnt_q};
            end
            StRefill: begin
                stall  = 1'b1;
                refill = 1'b1;
            end
            StWriteMem: begin
                stall     = ~mem_ready;
                mem_write = 1'b1;
                // Write-through: the cached copy is touched only when it is present.
                update    = mem_ready & hit;
            end
            default: stall = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: read miss fill, read hit, write hit/miss,
// reset during a fill and simultaneous read/write requests.
module tb_cache_controller;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         cpu_read, cpu_write;
    logic [9:0]   cpu_addr;
    logic [31:0]  cpu_wdata;
    logic         stall, hit, refill, update;
    logic [1:0]   offset;
    logic [4:0]   index;
    logic [2:0]   tag;
    logic [127:0] line_data;
    logic [31:0]  write_data;
    logic         mem_read, mem_write;
    logic [9:0]   mem_addr;
    logic [31:0]  mem_wdata, mem_rdata;
    logic         mem_ready;

    int n_checks = 0;
    int n_fail   = 0;

    cache_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_read   (cpu_read),
        .cpu_write  (cpu_write),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .stall      (stall),
        .hit        (hit),
        .refill     (refill),
        .update     (update),
        .offset     (offset),
        .index      (index),
        .tag        (tag),
        .line_data  (line_data),
        .write_data (write_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    // Mutual-exclusion invariants, sampled every cycle.
    always begin
        @(negedge clk);
        #1;
        check("excl_refill_update", {127'd0, refill & update}, 128'd0);
        check("excl_mem_rw", {127'd0, mem_read & mem_write}, 128'd0);
    end

    // Read miss with 2-cycle memory latency per word, then REFILL and the IDLE hit cycle.
    task automatic do_fill(input logic [9:0] addr, input logic [3:0][31:0] words,
                           input logic [127:0] exp_line);
        logic [1:0] kk;
        drive_edge();
        cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = addr; hit = 1'b0;
        @(negedge clk);
        check("miss_idle_stall", {127'd0, stall}, 128'd1);
        check("miss_idle_no_read", {127'd0, mem_read}, 128'd0);
        for (int k = 0; k < 4; k++) begin
            kk = k[1:0];
            drive_edge();
            mem_ready = 1'b0;
            @(negedge clk);
            check("fill_mem_read", {127'd0, mem_read}, 128'd1);
            check("fill_mem_addr", {118'd0, mem_addr}, {118'd0, addr[9:2], kk});
            check("fill_stall", {127'd0, stall}, 128'd1);
            check("fill_no_refill", {127'd0, refill}, 128'd0);
            drive_edge();
            mem_ready = 1'b1; mem_rdata = words[k];
            @(negedge clk);
            check("fill_addr_held", {118'd0, mem_addr}, {118'd0, addr[9:2], kk});
        end
        drive_edge();
        mem_ready = 1'b0; mem_rdata = '0;
        @(negedge clk);
        check("refill_pulse", {127'd0, refill}, 128'd1);
        check("refill_line", line_data, exp_line);
        check("refill_stall", {127'd0, stall}, 128'd1);
        check("refill_no_read", {127'd0, mem_read}, 128'd0);
        drive_edge();
        hit = 1'b1;
        @(negedge clk);
        check("after_refill_stall", {127'd0, stall}, 128'd0);
        check("after_refill_pulse", {127'd0, refill}, 128'd0);
        check("line_held", line_data, exp_line);
        drive_edge();
        cpu_read = 1'b0; hit = 1'b0;
    endtask

    // Store with memory ready on the third WRITE_MEM cycle.
    task automatic do_write(input logic [9:0] addr, input logic [31:0] data, input logic hit_v,
                            input logic also_read);
        drive_edge();
        cpu_write = 1'b1; cpu_read = also_read; cpu_addr = addr; cpu_wdata = data; hit = hit_v;
        @(negedge clk);
        check("wr_idle_stall", {127'd0, stall}, 128'd1);
        check("wr_idle_no_write", {127'd0, mem_write}, 128'd0);
        check("wr_write_data", {96'd0, write_data}, {96'd0, data});
        for (int i = 0; i < 2; i++) begin
            drive_edge();
            @(negedge clk);
            check("wr_mem_write", {127'd0, mem_write}, 128'd1);
            check("wr_no_mem_read", {127'd0, mem_read}, 128'd0);
            check("wr_mem_addr", {118'd0, mem_addr}, {118'd0, addr});
            check("wr_mem_wdata", {96'd0, mem_wdata}, {96'd0, data});
            check("wr_wait_update", {127'd0, update}, 128'd0);
            check("wr_wait_stall", {127'd0, stall}, 128'd1);
        end
        drive_edge();
        mem_ready = 1'b1;
        @(negedge clk);
        check("wr_ready_update", {127'd0, update}, {127'd0, hit_v});
        check("wr_ready_stall", {127'd0, stall}, 128'd0);
        check("wr_ready_no_refill", {127'd0, refill}, 128'd0);
        drive_edge();
        mem_ready = 1'b0; cpu_write = 1'b0; cpu_read = 1'b0; hit = 1'b0;
        @(negedge clk);
        check("wr_done_no_write", {127'd0, mem_write}, 128'd0);
        check("wr_done_no_update", {127'd0, update}, 128'd0);
        check("wr_done_no_fill", {127'd0, mem_read}, 128'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        hit = 1'b0; mem_rdata = '0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_refill", {127'd0, refill}, 128'd0);
        check("rst_update", {127'd0, update}, 128'd0);
        check("rst_mem_read", {127'd0, mem_read}, 128'd0);
        check("rst_mem_write", {127'd0, mem_write}, 128'd0);
        check("rst_line", line_data, 128'd0);
        check("rst_stall", {127'd0, stall}, 128'd0);
        reset_n = 1'b1;

        do_fill(10'h000, {32'h44, 32'h33, 32'h22, 32'h11},
                128'h00000044_00000033_00000022_00000011);

        // Zero-wait read hit
        drive_edge();
        cpu_read = 1'b1; cpu_addr = 10'h3A5; hit = 1'b1;
        @(negedge clk);
        check("hit_stall", {127'd0, stall}, 128'd0);
        check("hit_index", {123'd0, index}, 128'h09);
        check("hit_tag", {125'd0, tag}, 128'h7);
        check("hit_offset", {126'd0, offset}, 128'h1);
        check("hit_no_mem_read", {127'd0, mem_read}, 128'd0);
        drive_edge();
        @(negedge clk);
        check("hit_still_idle", {127'd0, mem_read}, 128'd0);
        drive_edge();
        cpu_read = 1'b0; hit = 1'b0;

        do_write(10'h125, 32'hDEADBEEF, 1'b1, 1'b0);
        do_write(10'h2C6, 32'h0BADF00D, 1'b0, 1'b0);

        // Reset after the second word of a fill
        drive_edge();
        cpu_read = 1'b1; cpu_addr = 10'h040; hit = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            drive_edge();
            mem_ready = 1'b0;
            @(negedge clk);
            check("partial_addr", {118'd0, mem_addr}, {118'd0, 10'h040 + 10'(k)});
            drive_edge();
            mem_ready = 1'b1; mem_rdata = 32'hA0 + 32'(k);
            @(negedge clk);
        end
        drive_edge();
        mem_ready = 1'b0; cpu_read = 1'b0; reset_n = 1'b0;
        #1;
        check("midrst_mem_read", {127'd0, mem_read}, 128'd0);
        check("midrst_refill", {127'd0, refill}, 128'd0);
        check("midrst_line", line_data, 128'd0);
        check("midrst_stall", {127'd0, stall}, 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        do_fill(10'h040, {32'hB3, 32'hB2, 32'hB1, 32'hB0},
                128'h000000B3_000000B2_000000B1_000000B0);

        // Simultaneous read and write on a hit behaves as a write
        do_write(10'h0A0, 32'h12345678, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
